// File: rtl/tetris_pkg.sv
// Shared definitions for the scripted command source: opcodes, sequencer
// states and helpers that split a ROM word into opcode and operand.
package tetris_pkg;

    localparam int unsigned OP_NOP  = 32'h00;
    localparam int unsigned OP_EMIT = 32'h01;
    localparam int unsigned OP_WAIT = 32'h02;
    localparam int unsigned OP_JUMP = 32'h03;
    localparam int unsigned OP_HALT = 32'h04;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        EMIT,
        WAIT,
        HALT
    } seq_state_t;

    // Words are passed zero-extended to 64 bits so one helper serves any WIDTH.
    function automatic logic [31:0] opcode_of(input logic [63:0] word, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 32'((word >> w) & mask);
    endfunction

    function automatic logic [31:0] operand_of(input logic [63:0] word, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 32'(word & mask);
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Read-side master for the instructions ROM: fetches, decodes and executes
// NOP/EMIT/WAIT/JUMP/HALT, offering EMIT payloads over a valid/ready handshake.
module instr_sequencer
    import tetris_pkg::*;
#(
    parameter int WIDTH               = 8,
    parameter int INSTRACTION_NUMBERS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tick,
    output logic [WIDTH-1:0]     curr_command,
    input  logic [2*WIDTH-1:0]   rom_data,
    output logic                 cmd_valid,
    output logic [WIDTH-1:0]     cmd_data,
    input  logic                 cmd_ready,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal
);

    localparam logic [WIDTH-1:0] PC_LAST = WIDTH'(INSTRACTION_NUMBERS - 1);

    seq_state_t           state, state_nxt;
    logic [WIDTH-1:0]     pc, pc_nxt;
    logic [2*WIDTH-1:0]   instr_reg, instr_nxt;
    logic [WIDTH-1:0]     wait_cnt, wait_nxt;
    logic                 cmd_valid_nxt;
    logic [WIDTH-1:0]     cmd_data_nxt;
    logic                 illegal_nxt;
    logic [WIDTH-1:0]     opcode;
    logic [WIDTH-1:0]     operand;

    // The program counter wraps inside the ROM so it can never address past it.
    function automatic logic [WIDTH-1:0] next_pc(input logic [WIDTH-1:0] p);
        return (p == PC_LAST) ? '0 : p + WIDTH'(1);
    endfunction

    assign opcode  = WIDTH'(opcode_of(64'(instr_reg), WIDTH));
    assign operand = WIDTH'(operand_of(64'(instr_reg), WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            instr_reg <= '0;
            wait_cnt  <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            instr_reg <= instr_nxt;
            wait_cnt  <= wait_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd_data  <= cmd_data_nxt;
            illegal   <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        instr_nxt     = instr_reg;
        wait_nxt      = wait_cnt;
        cmd_valid_nxt = cmd_valid;
        cmd_data_nxt  = cmd_data;
        illegal_nxt   = illegal;

        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt   = FETCH;
                    pc_nxt      = '0;
                    illegal_nxt = 1'b0;
                end
            end
            FETCH: begin
                instr_nxt = rom_data;
                state_nxt = EXEC;
            end
            EXEC: begin
                case (32'(opcode))
                    OP_NOP: begin
                        pc_nxt    = next_pc(pc);
                        state_nxt = FETCH;
                    end
                    OP_EMIT: begin
                        // Registered here so valid and payload appear together on EMIT entry.
                        cmd_valid_nxt = 1'b1;
                        cmd_data_nxt  = operand;
                        state_nxt     = EMIT;
                    end
                    OP_WAIT: begin
                        if (operand == '0) begin
                            pc_nxt    = next_pc(pc);
                            state_nxt = FETCH;
                        end else begin
                            wait_nxt  = operand;
                            state_nxt = WAIT;
                        end
                    end
                    OP_JUMP: begin
                        if (32'(operand) < 32'(INSTRACTION_NUMBERS)) begin
                            pc_nxt = operand;
                        end else begin
                            pc_nxt      = '0;
                            illegal_nxt = 1'b1;
                        end
                        state_nxt = FETCH;
                    end
                    OP_HALT: begin
                        state_nxt = HALT;
                    end
                    default: begin
                        pc_nxt      = next_pc(pc);
                        illegal_nxt = 1'b1;
                        state_nxt   = FETCH;
                    end
                endcase
            end
            EMIT: begin
                if (cmd_ready) begin
                    cmd_valid_nxt = 1'b0;
                    pc_nxt        = next_pc(pc);
                    state_nxt     = FETCH;
                end
            end
            WAIT: begin
                // Only ticks seen in this state count towards the delay.
                if (tick) begin
                    wait_nxt = wait_cnt - WIDTH'(1);
                    if (wait_cnt == WIDTH'(1)) begin
                        pc_nxt    = next_pc(pc);
                        state_nxt = FETCH;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign curr_command = pc;
    assign busy         = (state != IDLE) && (state != HALT);
    assign halted       = (state == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small behavioural ROM alongside.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic [7:0]  curr_command;
    logic [15:0] rom_data;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_ready = 1'b1;
    logic        busy;
    logic        halted;
    logic        illegal;

    logic [15:0] rom [4];
    logic [7:0]  xq [$];
    int          vcnt = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    instr_sequencer #(.WIDTH(8), .INSTRACTION_NUMBERS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tick         (tick),
        .curr_command (curr_command),
        .rom_data     (rom_data),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .busy         (busy),
        .halted       (halted),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        rom_data = (curr_command < 8'd4) ? rom[curr_command[1:0]] : 16'h0000;
    end

    // Transfers are logged mid-cycle, where valid and ready are both settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) vcnt++;
            if (cmd_valid && cmd_ready) xq.push_back(cmd_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (cmd_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_halt(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        bit          ok;
        int          xb;
        int          vb;
        int          held;
        int          first_c;
        logic [7:0]  exp_pc [7] = '{8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};

        rom[0] = 16'h0105; rom[1] = 16'h0107; rom[2] = 16'h0400; rom[3] = 16'h0000;
        do_reset();
        check("rst_valid",   32'(cmd_valid),    32'd0);
        check("rst_busy",    32'(busy),         32'd0);
        check("rst_halted",  32'(halted),       32'd0);
        check("rst_illegal", 32'(illegal),      32'd0);
        check("rst_pc",      32'(curr_command), 32'd0);
        check("rst_data",    32'(cmd_data),     32'd0);

        // Two emits with ready tied high, then halt.
        xb = xq.size();
        vb = vcnt;
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        wait_halt(40, ok);
        check("t1_halt_seen", 32'(ok), 32'd1);
        check("t1_xfers", 32'(xq.size() - xb), 32'd2);
        if (xq.size() - xb == 2) begin
            check("t1_data0", 32'(xq[xb]),     32'h05);
            check("t1_data1", 32'(xq[xb + 1]), 32'h07);
        end
        check("t1_valid_cycles", 32'(vcnt - vb), 32'd2);
        check("t1_pc",   32'(curr_command), 32'd2);
        check("t1_busy", 32'(busy),         32'd0);

        // Backpressure: ready low for 5 cycles after valid rises.
        cmd_ready = 1'b0;
        xb = xq.size();
        pulse_start();
        wait_valid(10, ok);
        check("t2_valid_seen", 32'(ok), 32'd1);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_valid && cmd_data == 8'h05) held++;
            if (i < 4) step();
        end
        check("t2_held", 32'(held), 32'd5);
        cmd_ready = 1'b1;
        step();
        check("t2_valid_drop", 32'(cmd_valid), 32'd0);
        wait_halt(40, ok);
        check("t2_halt_seen", 32'(ok), 32'd1);
        check("t2_xfers", 32'(xq.size() - xb), 32'd2);
        if (xq.size() - xb == 2) begin
            check("t2_data0", 32'(xq[xb]),     32'h05);
            check("t2_data1", 32'(xq[xb + 1]), 32'h07);
        end

        // Timed wait of 3 ticks, tick strobed every 4 cycles.
        rom[0] = 16'h0203; rom[1] = 16'h0109;
        pulse_start();
        first_c = -1;
        for (int c = 0; c < 40; c++) begin
            tick = (c % 4 == 3);
            step();
            tick = 1'b0;
            if (cmd_valid) begin
                first_c = c;
                break;
            end
        end
        check("t3_first_valid", 32'(first_c), 32'd13);
        check("t3_data", 32'(cmd_data), 32'h09);
        wait_halt(20, ok);
        check("t3_halt_seen", 32'(ok), 32'd1);

        // Zero-length wait: no tick needed.
        rom[0] = 16'h0200;
        pulse_start();
        first_c = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (cmd_valid) begin
                first_c = c;
                break;
            end
        end
        check("t3_wait0_first_valid", 32'(first_c), 32'd3);
        wait_halt(20, ok);
        check("t3_wait0_halt", 32'(ok), 32'd1);

        // Legal jump loop 0,1,0,1.
        rom[0] = 16'h0000; rom[1] = 16'h0300; rom[2] = 16'h0000; rom[3] = 16'h0000;
        vb = vcnt;
        pulse_start();
        check("t4_pc_start", 32'(curr_command), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("t4_pc_%0d", i), 32'(curr_command), 32'(exp_pc[i]));
        end
        check("t4_busy",    32'(busy),       32'd1);
        check("t4_novalid", 32'(vcnt - vb),  32'd0);
        check("t4_illegal", 32'(illegal),    32'd0);

        // Out-of-range jump.
        do_reset();
        rom[1] = 16'h0309;
        pulse_start();
        for (int i = 0; i < 4; i++) step();
        check("t4_bad_pc",      32'(curr_command), 32'd0);
        check("t4_bad_illegal", 32'(illegal),      32'd1);
        rom[0] = 16'h0400;
        step();
        step();
        check("t4_bad_halted",  32'(halted),  32'd1);
        check("t4_sticky",      32'(illegal), 32'd1);
        pulse_start();
        check("t4_clear_on_start", 32'(illegal), 32'd0);
        wait_halt(20, ok);
        check("t4_rehalt", 32'(ok), 32'd1);

        // Wrap from address 3 back to 0.
        do_reset();
        rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0000; rom[3] = 16'h0101;
        xb = xq.size();
        pulse_start();
        for (int i = 0; i < 6; i++) step();
        check("t5_pc3", 32'(curr_command), 32'd3);
        for (int i = 0; i < 3; i++) step();
        check("t5_wrap_pc", 32'(curr_command), 32'd0);
        check("t5_xfers", 32'(xq.size() - xb), 32'd1);
        if (xq.size() - xb == 1) check("t5_data", 32'(xq[xb]), 32'h01);

        // Undefined opcode runs as NOP and flags illegal.
        do_reset();
        rom[0] = 16'h7F00; rom[1] = 16'h0400;
        pulse_start();
        step();
        check("t5_ill_before", 32'(illegal), 32'd0);
        step();
        check("t5_ill_after", 32'(illegal),      32'd1);
        check("t5_ill_pc",    32'(curr_command), 32'd1);
        step();
        step();
        check("t5_ill_halted", 32'(halted), 32'd1);

        // Asynchronous reset in the middle of a pending handshake.
        do_reset();
        rom[0] = 16'h0105; rom[1] = 16'h0107; rom[2] = 16'h0400; rom[3] = 16'h0000;
        cmd_ready = 1'b0;
        pulse_start();
        wait_valid(10, ok);
        check("t6_valid_seen", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(cmd_valid),    32'd0);
        check("t6_async_busy",  32'(busy),         32'd0);
        check("t6_async_pc",    32'(curr_command), 32'd0);
        step();
        rst = 1'b0;
        cmd_ready = 1'b1;
        step();
        xb = xq.size();
        pulse_start();
        check("t6_restart_pc", 32'(curr_command), 32'd0);
        wait_halt(40, ok);
        check("t6_halt_seen", 32'(ok), 32'd1);
        check("t6_xfers", 32'(xq.size() - xb), 32'd2);
        if (xq.size() - xb == 2) begin
            check("t6_data0", 32'(xq[xb]),     32'h05);
            check("t6_data1", 32'(xq[xb + 1]), 32'h07);
        end
        check("t6_pc", 32'(curr_command), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Read-side master for the `instructions` ROM.
- Drives the ROM address (`curr_command`) and captures each 2*WIDTH-bit word it returns.
- Splits the word into opcode (upper WIDTH bits) and operand (lower WIDTH bits), then executes it.
- Issues move commands to the game core over a valid/ready handshake; supports timed waits, jumps and halt. Sits between the ROM and the tetris game logic as a scripted command source.

Parameters:
- WIDTH, 8: address, opcode and operand width; the ROM word is 2*WIDTH.
- INSTRACTION_NUMBERS, 4: ROM depth. Legal addresses are 0..INSTRACTION_NUMBERS-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins the program from address 0 when in IDLE or HALT.
- tick  in  1  one-cycle time-base strobe; only WAIT counts it.
- curr_command  out  WIDTH  ROM address (the program counter, pc).
- rom_data  in  2*WIDTH  ROM word. Combinational from curr_command, valid in the same cycle.
- cmd_valid  out  1  command offered to game core.
- cmd_data  out  WIDTH  command payload (the EMIT operand).
- cmd_ready  in  1  game core accepts the command.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky flag: undefined opcode or out-of-range jump seen. Cleared by rst or start.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, pc = 0, instr_reg = 0, wait_cnt = 0.
  - cmd_valid = 0, cmd_data = 0, busy = 0, halted = 0, illegal = 0.
  - Reset mid-operation aborts immediately, including a pending handshake; cmd_valid drops asynchronously.
- Opcodes (upper WIDTH bits):
  - 0x00 NOP.
  - 0x01 EMIT.
  - 0x02 WAIT.
  - 0x03 JUMP.
  - 0x04 HALT.
  - Any other value is executed as NOP and sets illegal.
- States and transitions:
  - IDLE: start -> FETCH, with pc = 0 and illegal cleared.
  - FETCH (1 cycle): instr_reg <= rom_data; -> EXEC.
  - EXEC (1 cycle) decodes instr_reg:
    - NOP: pc <= next(pc); -> FETCH.
    - EMIT: -> EMIT.
    - WAIT with operand 0: pc <= next(pc); -> FETCH.
    - WAIT with operand n > 0: wait_cnt <= n; -> WAIT.
    - JUMP to target < INSTRACTION_NUMBERS: pc <= target; -> FETCH.
    - JUMP to target >= INSTRACTION_NUMBERS: pc <= 0, illegal <= 1; -> FETCH.
    - HALT: -> HALT.
  - EMIT:
    - cmd_valid = 1 and cmd_data = operand, both registered and stable until the transfer.
    - Transfer happens on the cycle with cmd_valid & cmd_ready. On that edge cmd_valid <= 0, pc <= next(pc); -> FETCH.
    - cmd_ready is ignored outside EMIT.
  - WAIT:
    - Each tick decrements wait_cnt.
    - A tick that takes wait_cnt from 1 to 0 also does pc <= next(pc); -> FETCH.
    - Total wait is exactly n tick pulses after entering WAIT. A tick during FETCH/EXEC is not counted.
  - HALT: halted = 1, busy = 0. start -> FETCH with pc = 0 and illegal cleared. Otherwise stay.
- start is ignored while busy.
- next(pc) = pc + 1, wrapping to 0 when pc == INSTRACTION_NUMBERS-1; pc never leaves the legal range.
- Latency:
  - start to first curr_command sample: 1 cycle.
  - NOP/JUMP: 2 cycles per instruction.
  - EMIT: cmd_valid rises 2 cycles after FETCH entry; best case 3 cycles per EMIT.

Decomposition:
- Shared package `tetris_pkg`:
  - opcode constants OP_NOP..OP_HALT.
  - state enum IDLE/FETCH/EXEC/EMIT/WAIT/HALT.
  - opcode/operand field slice helpers.
- No sub-module. The `instructions` ROM is instantiated alongside this block by the parent and wired curr_command -> curr_command, out_data -> rom_data.

Test Plan:
- Program {0x0105, 0x0107, 0x0400, x}, cmd_ready tied 1, pulse start -> exactly two transfers, cmd_data 0x05 then 0x07, each cmd_valid exactly 1 cycle; halted = 1 and pc = 2 afterwards.
- Same program, cmd_ready low for 5 cycles after cmd_valid rises -> cmd_valid and cmd_data = 0x05 held all 5 cycles; single transfer on the ready cycle; no duplicate.
- Program {0x0203, 0x0109, 0x0400, x}, tick every 4 cycles -> cmd_valid for 0x09 appears only after the 3rd counted tick; a WAIT operand of 0x00 instead adds no tick dependency.
- Program {0x0000, 0x0300, x, x} -> pc loops 0,1,0,1 with busy = 1 and no cmd_valid. With the jump operand changed to 0x09 -> pc goes to 0 and illegal = 1, held sticky until the next start.
- Program at depth 4 of {0x0000, 0x0000, 0x0000, 0x0101} -> after address 3, pc wraps to 0. Opcode 0x7F word -> treated as NOP and illegal set.
- Assert rst during EMIT with cmd_valid high -> cmd_valid, busy and pc go to 0 without a clock edge; a later start restarts from address 0.
